// File: rtl/ann_layer_sequencer_if.sv
// Datapath-facing bundle between the layer sequencer and the MAC / activation / backprop units.
// Sequencer drives operand selection, MAC control and write-back; backprop answers with bp_done.
interface ann_seq_if;
    logic       mac_clr;
    logic       mac_en;
    logic       src_sel;
    logic [4:0] in_idx;
    logic [7:0] w_addr;
    logic       act_we;
    logic       act_layer;
    logic [2:0] act_idx;
    logic       bp_start;
    logic       bp_done;

    modport master (
        output mac_clr, mac_en, src_sel, in_idx, w_addr,
        output act_we, act_layer, act_idx, bp_start,
        input  bp_done
    );

    modport slave (
        input  mac_clr, mac_en, src_sel, in_idx, w_addr,
        input  act_we, act_layer, act_idx, bp_start,
        output bp_done
    );
endinterface

// File: rtl/ann_layer_sequencer.sv
// Moore sequencer sharing one MAC across all hidden/output neurons, with optional backprop epochs.
// Optional stall input hold_i is built only when SEQ_HOLD_EN is defined.
module ann_layer_sequencer #(
    parameter int N_IN      = 30,
    parameter int N_HID     = 5,
    parameter int N_OUT     = 3,
    parameter int ACT_LAT   = 2,
    parameter int MAX_EPOCH = 100
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       training_i,
`ifdef SEQ_HOLD_EN
    input  logic       hold_i,
`endif
    ann_seq_if.master  dp,
    output logic [9:0] epoch_o,
    output logic       done_o,
    output logic       done_training_o,
    output logic [4:0] state_o
);

    typedef enum logic [4:0] {
        IDLE     = 5'd0,
        HID_CLR  = 5'd1,
        HID_MAC  = 5'd2,
        HID_WAIT = 5'd3,
        HID_WR   = 5'd4,
        OUT_CLR  = 5'd5,
        OUT_MAC  = 5'd6,
        OUT_WAIT = 5'd7,
        OUT_WR   = 5'd8,
        BP       = 5'd9,
        BP_WAIT  = 5'd10,
        DONE     = 5'd11
    } state_t;

    localparam logic [4:0] HID_I_LAST = 5'(N_IN - 1);
    localparam logic [4:0] OUT_I_LAST = 5'(N_HID - 1);
    localparam logic [4:0] LAT_LAST   = 5'(ACT_LAT - 1);
    localparam logic [2:0] HID_N_LAST = 3'(N_HID - 1);
    localparam logic [2:0] OUT_N_LAST = 3'(N_OUT - 1);
    localparam logic [7:0] OUT_BASE   = 8'(N_HID * N_IN);
    localparam logic [9:0] EPOCH_MAX  = 10'(MAX_EPOCH);

    state_t     state_q, state_d;
    logic [2:0] n_q, n_d;
    logic [4:0] i_q, i_d;
    logic       mode_q, mode_d;
    logic [9:0] epoch_q, epoch_d;
    logic       dt_q, dt_d;
    logic       stall;

`ifdef SEQ_HOLD_EN
    assign stall = hold_i;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            i_q     <= '0;
            mode_q  <= 1'b0;
            epoch_q <= '0;
            dt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            mode_q  <= mode_d;
            epoch_q <= epoch_d;
            dt_q    <= dt_d;
        end
    end

    // i_q doubles as the MAC operand index and the activation-latency counter.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        mode_d  = mode_q;
        epoch_d = epoch_q;
        dt_d    = dt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d  = training_i & ~dt_q;
                    n_d     = '0;
                    state_d = HID_CLR;
                end
            end
            HID_CLR: begin
                i_d     = '0;
                state_d = HID_MAC;
            end
            HID_MAC: begin
                if (!stall) begin
                    if (i_q == HID_I_LAST) begin
                        i_d     = '0;
                        state_d = HID_WAIT;
                    end else begin
                        i_d = i_q + 5'd1;
                    end
                end
            end
            HID_WAIT: begin
                if (i_q == LAT_LAST) begin
                    i_d     = '0;
                    state_d = HID_WR;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            HID_WR: begin
                if (n_q == HID_N_LAST) begin
                    n_d     = '0;
                    state_d = OUT_CLR;
                end else begin
                    n_d     = n_q + 3'd1;
                    state_d = HID_CLR;
                end
            end
            OUT_CLR: begin
                i_d     = '0;
                state_d = OUT_MAC;
            end
            OUT_MAC: begin
                if (!stall) begin
                    if (i_q == OUT_I_LAST) begin
                        i_d     = '0;
                        state_d = OUT_WAIT;
                    end else begin
                        i_d = i_q + 5'd1;
                    end
                end
            end
            OUT_WAIT: begin
                if (i_q == LAT_LAST) begin
                    i_d     = '0;
                    state_d = OUT_WR;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            OUT_WR: begin
                if (n_q == OUT_N_LAST) begin
                    n_d     = '0;
                    state_d = mode_q ? BP : DONE;
                end else begin
                    n_d     = n_q + 3'd1;
                    state_d = OUT_CLR;
                end
            end
            BP: state_d = BP_WAIT;
            BP_WAIT: begin
                if (dp.bp_done) begin
                    epoch_d = (epoch_q < EPOCH_MAX) ? epoch_q + 10'd1 : epoch_q;
                    if (epoch_d == EPOCH_MAX) begin
                        dt_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        n_d     = '0;
                        state_d = HID_CLR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dp.mac_clr   = 1'b0;
        dp.mac_en    = 1'b0;
        dp.src_sel   = 1'b0;
        dp.in_idx    = '0;
        dp.w_addr    = '0;
        dp.act_we    = 1'b0;
        dp.act_layer = 1'b0;
        dp.act_idx   = '0;
        dp.bp_start  = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            HID_CLR, OUT_CLR: dp.mac_clr = 1'b1;
            HID_MAC: begin
                dp.mac_en = ~stall;
                dp.in_idx = i_q;
                dp.w_addr = 8'(n_q) * 8'(N_IN) + 8'(i_q);
            end
            OUT_MAC: begin
                dp.mac_en  = ~stall;
                dp.src_sel = 1'b1;
                dp.in_idx  = i_q;
                dp.w_addr  = OUT_BASE + 8'(n_q) * 8'(N_HID) + 8'(i_q);
            end
            HID_WR: begin
                dp.act_we  = 1'b1;
                dp.act_idx = n_q;
            end
            OUT_WR: begin
                dp.act_we    = 1'b1;
                dp.act_layer = 1'b1;
                dp.act_idx   = n_q;
            end
            BP:      dp.bp_start = 1'b1;
            DONE:    done_o      = 1'b1;
            default: ;
        endcase
    end

    assign epoch_o         = epoch_q;
    assign done_training_o = dt_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Directed bench for ann_layer_sequencer (MAX_EPOCH reduced to 3); hold test built with SEQ_HOLD_EN.
module tb_ann_layer_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       training_i;
    logic       hold_i;
    logic [9:0] epoch_o;
    logic       done_o;
    logic       done_training_o;
    logic [4:0] state_o;

    ann_seq_if dp_if ();

    ann_layer_sequencer #(.MAX_EPOCH(3)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .training_i      (training_i),
`ifdef SEQ_HOLD_EN
        .hold_i          (hold_i),
`endif
        .dp              (dp_if.master),
        .epoch_o         (epoch_o),
        .done_o          (done_o),
        .done_training_o (done_training_o),
        .state_o         (state_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // per-pass statistics gathered by observe()
    int done_cyc, hid0_cyc, out2_cyc, bp_cnt, addr_err, exp_addr;
    int clr1, addr2, addr31, src172, layer179, held_ok, ep_changes, ep_bad, timed_out;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Launches a pass from IDLE and runs until done; cycle 1 is the first HID_CLR cycle.
    task automatic observe(input logic trn, input int restart_c, input int stray_c,
                           input int hold_lo, input int hold_hi);
        int c;
        int bp_due;
        logic [9:0] ep_prev;
        done_cyc = -1; hid0_cyc = -1; out2_cyc = -1; bp_cnt = 0; addr_err = 0; exp_addr = 0;
        clr1 = -1; addr2 = -1; addr31 = -1; src172 = -1; layer179 = -1; held_ok = 0;
        ep_changes = 0; ep_bad = 0; timed_out = 0;
        ep_prev = epoch_o;
        bp_due = -1;
        training_i = trn;
        start_i = 1'b1;
        tick();
        c = 1;
        forever begin
            start_i       = (c == restart_c);
            dp_if.bp_done = (c == bp_due) || (c == stray_c);
            hold_i        = (c >= hold_lo) && (c <= hold_hi);
            #1;
            if (c == 1)   clr1     = int'(dp_if.mac_clr);
            if (c == 2)   addr2    = int'(dp_if.w_addr);
            if (c == 31)  addr31   = int'(dp_if.w_addr);
            if (c == 172) src172   = int'(dp_if.src_sel);
            if (c == 179) layer179 = int'(dp_if.act_layer);
            if (dp_if.mac_en) begin
                if (int'(dp_if.w_addr) != exp_addr) addr_err++;
                exp_addr++;
            end
            if (hold_i && !dp_if.mac_en && dp_if.w_addr == 8'd8) held_ok++;
            if (dp_if.act_we && !dp_if.act_layer && dp_if.act_idx == 3'd0 && hid0_cyc < 0)
                hid0_cyc = c;
            if (dp_if.act_we && dp_if.act_layer && dp_if.act_idx == 3'd2 && out2_cyc < 0)
                out2_cyc = c;
            if (dp_if.bp_start) begin
                bp_cnt++;
                bp_due   = c + 4;
                exp_addr = 0;
            end
            if (epoch_o != ep_prev) begin
                ep_changes++;
                if (epoch_o != ep_prev + 10'd1) ep_bad++;
                ep_prev = epoch_o;
            end
            if (done_o) begin
                done_cyc = c;
                break;
            end
            if (c >= 5000) begin
                timed_out = 1;
                break;
            end
            tick();
            c++;
        end
        start_i       = 1'b0;
        dp_if.bp_done = 1'b0;
        hold_i        = 1'b0;
        tick();
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; training_i = 1'b0; hold_i = 1'b0; dp_if.bp_done = 1'b0;
        tick();
        tick();
        chk("reset_state", int'(state_o), 0);
        chk("reset_epoch", int'(epoch_o), 0);
        chk("reset_dtrain", int'(done_training_o), 0);
        chk("reset_mac_en", int'(dp_if.mac_en), 0);
        chk("reset_done", int'(done_o), 0);
        rst_i = 1'b0;
        tick();

        // Inference pass
        observe(1'b0, -1, -1, -1, -1);
        chk("inf_timeout", timed_out, 0);
        chk("inf_clr_c1", clr1, 1);
        chk("inf_addr_c2", addr2, 0);
        chk("inf_addr_c31", addr31, 29);
        chk("inf_hid0_we", hid0_cyc, 34);
        chk("inf_src_sel", src172, 1);
        chk("inf_act_layer", layer179, 1);
        chk("inf_out2_we", out2_cyc, 197);
        chk("inf_done", done_cyc, 198);
        chk("inf_bp_cnt", bp_cnt, 0);
        chk("inf_addr_err", addr_err, 0);
        chk("inf_addr_total", exp_addr, 165);
        chk("inf_idle_after", int'(state_o), 0);
        chk("inf_done_pulse", int'(done_o), 0);

        // Stray Start and bp_done mid-pass
        observe(1'b0, 50, 40, -1, -1);
        chk("stray_timeout", timed_out, 0);
        chk("stray_done", done_cyc, 198);
        chk("stray_bp_cnt", bp_cnt, 0);
        chk("stray_epoch", int'(epoch_o), 0);

        // Training to MAX_EPOCH = 3, bp_done 4 cycles after each bp_start
        observe(1'b1, -1, -1, -1, -1);
        chk("trn_timeout", timed_out, 0);
        chk("trn_bp_cnt", bp_cnt, 3);
        chk("trn_epoch", int'(epoch_o), 3);
        chk("trn_ep_steps", ep_changes, 3);
        chk("trn_ep_bad", ep_bad, 0);
        chk("trn_dtrain", int'(done_training_o), 1);
        chk("trn_done", done_cyc, 607);
        chk("trn_addr_err", addr_err, 0);
        chk("trn_done_pulse", int'(done_o), 0);

        // Training request after completion runs inference only
        observe(1'b1, -1, -1, -1, -1);
        chk("post_timeout", timed_out, 0);
        chk("post_done", done_cyc, 198);
        chk("post_bp_cnt", bp_cnt, 0);
        chk("post_epoch", int'(epoch_o), 3);
        chk("post_dtrain", int'(done_training_o), 1);

        // Reset mid-run clears everything
        training_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (20) tick();
        chk("mid_busy", int'(state_o), 2);
        rst_i = 1'b1;
        tick();
        tick();
        chk("rst_state", int'(state_o), 0);
        chk("rst_mac_en", int'(dp_if.mac_en), 0);
        chk("rst_act_we", int'(dp_if.act_we), 0);
        chk("rst_bp_start", int'(dp_if.bp_start), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_epoch", int'(epoch_o), 0);
        chk("rst_dtrain", int'(done_training_o), 0);
        rst_i = 1'b0;
        tick();

`ifdef SEQ_HOLD_EN
        observe(1'b0, -1, -1, 10, 14);
        chk("hold_timeout", timed_out, 0);
        chk("hold_frozen", held_ok, 5);
        chk("hold_done", done_cyc, 203);
        chk("hold_addr_err", addr_err, 0);
        chk("hold_addr_total", exp_addr, 165);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
